dma_bus_arbiter: RTL and testbench
==================================

Name: dma_bus_arbiter

Overview:
Parametrised system-bus owner arbiter that generalises CPU/MARIA bus sharing to NUM_MASTERS read-only DMA masters. The CPU owns the bus by default. DMA requests halt the CPU at a pclk1 boundary, one master is granted, and ownership returns to the CPU at a pclk1 boundary. Sits between the 6502 wrapper, the DMA masters (MARIA, future blitter/expansion) and the chip-select/memory fabric, replacing the ad-hoc address/RW mux.

Parameters:
NUM_MASTERS, 2, number of DMA masters (1..8); index 0 has highest fixed priority.
AW, 16, address bus width.
MAX_HOLD, 0, maximum pclk1 strobes a single grant may last; 0 = unlimited.

Ports:
clk_sys  in  1  system clock.
rst  in  1  synchronous active-high reset.
pclk1  in  1  CPU phase-1 strobe, one clk_sys wide.
halt_en  in  1  halting permitted (control register has reached its second write); 0 = requests ignored.
cpu_ab  in  AW  CPU address.
cpu_rw_n  in  1  CPU read/write_n.
req  in  NUM_MASTERS  per-master bus request, level.
m_ab  in  NUM_MASTERS*AW  master addresses, master i at [i*AW +: AW].
cpu_halt_n  out  1  halt to CPU core (enable gating).
cpu_released  out  1  CPU off bus.
grant  out  NUM_MASTERS  one-hot grant.
ab  out  AW  resolved system address.
rw_n  out  1  resolved read/write_n.
timeout  out  1  one-clk pulse when a MAX_HOLD expiry revokes a grant.

Behaviour:
- Reset values: state CPU_OWN, cpu_halt_n=1, cpu_released=0, grant=0, timeout=0, last_ab=0, hold counter=0.
- States: CPU_OWN, HALT_WAIT, DMA_OWN, RETURN. All outputs are registered except ab and rw_n, which are combinational from state, grant and the registered last_ab.
- CPU_OWN:
  - If halt_en && |req, go to HALT_WAIT and set cpu_halt_n=0 on the next clk.
  - Otherwise no change. With halt_en=0, req is ignored indefinitely.
- HALT_WAIT:
  - If all req drop before pclk1, return to CPU_OWN next clk with cpu_halt_n=1 and no grant issued.
  - On a pclk1 strobe with |req, go to DMA_OWN, set cpu_released=1 and grant = winner. Winner is the lowest set req index.
  - Grant appears on the same clk edge that samples pclk1.
- DMA_OWN:
  - Grant is held while the grantee's req=1.
  - When the grantee drops req:
    - If another req is set, regrant to the new winner at the next pclk1 strobe. grant=0 in between and the CPU stays halted.
    - Else go to RETURN with cpu_halt_n=1 and grant=0.
  - A higher-priority req arriving mid-grant does not preempt.
- RETURN:
  - On the next pclk1 strobe, go to CPU_OWN with cpu_released=0.
  - If |req && halt_en at that same strobe, go to HALT_WAIT instead, with cpu_halt_n=0 and cpu_released staying 1.
- Bus mux:
  - CPU_OWN / HALT_WAIT: ab=cpu_ab, rw_n=cpu_rw_n.
  - DMA_OWN with a grant: ab=m_ab[granted], rw_n=1.
  - DMA_OWN without a grant, and RETURN: ab=last_ab, rw_n=1.
  - last_ab registers ab every clk. DMA never writes.
- MAX_HOLD>0:
  - The counter increments on each pclk1 strobe while a grant is active and clears on a new grant.
  - When it reaches MAX_HOLD, grant is cleared and timeout pulses for 1 clk. The arbiter then behaves as if the grantee dropped req.
  - That master is masked from winning until its req is seen low.
- halt_en falling while in DMA_OWN does not abort the current grant; no new HALT_WAIT entry occurs.
- rst mid-operation returns immediately to the reset state. Grant drops the same clk.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: the winner is the first set req at or after (last_granted+1) mod NUM_MASTERS. The pointer resets to NUM_MASTERS-1, so master 0 wins first.
- Undefined: fixed priority, lowest index wins.
- All other behaviour is identical in both builds.

Test Plan:
- Idle: rst, then halt_en=1, req=0, cpu_ab=16'h1234, cpu_rw_n=0 -> ab=1234, rw_n=0, cpu_halt_n=1, grant=0 indefinitely.
- Single grant: req=01 -> cpu_halt_n=0 next clk. At the next pclk1, grant=01, cpu_released=1, ab=m_ab[0], rw_n=1. Drop req -> cpu_halt_n=1. Next pclk1 -> cpu_released=0, ab=cpu_ab.
- Gating and cancel:
  - halt_en=0, req=11 -> no halt for 100 clks.
  - halt_en=1, req pulsed for 2 clks before pclk1 -> HALT_WAIT, then back to CPU_OWN with grant never asserted.
- Priority: req=11 -> grant=01. Drop req[0] -> grant=00 for the gap, then grant=10 at the next pclk1 with ab=m_ab[1] and cpu_halt_n=0 throughout. With ARB_ROUND_ROBIN_EN, the next request cycle of req=11 grants 01, then 10 alternately.
- Timeout: MAX_HOLD=4, req=01 held -> grant lasts 4 pclk1 strobes, then timeout=1 for 1 clk and grant=0. Req=01 still high -> no regrant; drop and reassert -> normal regrant.
- Reset: rst asserted in DMA_OWN -> next clk grant=0, cpu_halt_n=1, cpu_released=0, ab=cpu_ab.

Source files
------------

// File: rtl/dma_bus_arbiter.sv
// System-bus owner arbiter: CPU owns the bus by default, DMA masters take it between pclk1 boundaries.
// Optional build macro ARB_ROUND_ROBIN_EN selects rotating priority instead of fixed lowest-index-wins.
module dma_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 16,
    parameter int MAX_HOLD    = 0
) (
    input  logic                      clk_sys,
    input  logic                      rst,
    input  logic                      pclk1,
    input  logic                      halt_en,
    input  logic [AW-1:0]             cpu_ab,
    input  logic                      cpu_rw_n,
    input  logic [NUM_MASTERS-1:0]    req,
    input  logic [NUM_MASTERS*AW-1:0] m_ab,
    output logic                      cpu_halt_n,
    output logic                      cpu_released,
    output logic [NUM_MASTERS-1:0]    grant,
    output logic [AW-1:0]             ab,
    output logic                      rw_n,
    output logic                      timeout
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        ST_CPU_OWN   = 2'd0,
        ST_HALT_WAIT = 2'd1,
        ST_DMA_OWN   = 2'd2,
        ST_RETURN    = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_halt_n;
    logic                   r_released;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IW-1:0]          r_gidx;
    logic                   r_timeout;
    logic [AW-1:0]          r_last_ab;
    logic [HW-1:0]          r_hold_cnt;
    logic [NUM_MASTERS-1:0] r_mask;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0]          r_ptr;
`endif

    logic [AW-1:0]          w_m_ab [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] w_eff;
    logic [NUM_MASTERS-1:0] w_others;
    logic                   w_any;
    logic                   w_grantee_req;
    logic                   w_hold_hit;
    logic [IW-1:0]          w_win;
    logic [NUM_MASTERS-1:0] w_win_oh;

`ifdef ARB_ROUND_ROBIN_EN
    // First set request at or after ptr+1, wrapping; scanned backwards so the nearest wins.
    function automatic logic [IW-1:0] f_winner(input logic [NUM_MASTERS-1:0] rq,
                                               input logic [IW-1:0] ptr);
        logic [IW-1:0] w;
        int            j;
        w = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            j = (32'(ptr) + k) % NUM_MASTERS;
            if (rq[j]) w = IW'(j);
        end
        return w;
    endfunction
`else
    function automatic logic [IW-1:0] f_winner(input logic [NUM_MASTERS-1:0] rq);
        logic [IW-1:0] w;
        w = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (rq[i]) w = IW'(i);
        end
        return w;
    endfunction
`endif

    // A master revoked by MAX_HOLD stays out of arbitration until it releases its request.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_m_ab[i] = m_ab[i*AW +: AW];
        end
        w_eff         = req & ~r_mask;
        w_any         = |w_eff;
        w_others      = w_eff & ~r_grant;
        w_grantee_req = |(req & r_grant);
        w_hold_hit    = (MAX_HOLD > 0) && pclk1 &&
                        ((32'(r_hold_cnt) + 32'd1) == 32'(MAX_HOLD));
`ifdef ARB_ROUND_ROBIN_EN
        w_win         = f_winner(w_eff, r_ptr);
`else
        w_win         = f_winner(w_eff);
`endif
        w_win_oh        = '0;
        w_win_oh[w_win] = 1'b1;
    end

    always_comb begin
        ab   = r_last_ab;
        rw_n = 1'b1;
        case (r_state)
            ST_CPU_OWN, ST_HALT_WAIT: begin
                ab   = cpu_ab;
                rw_n = cpu_rw_n;
            end
            ST_DMA_OWN: begin
                if (|r_grant) ab = w_m_ab[r_gidx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state    <= ST_CPU_OWN;
            r_halt_n   <= 1'b1;
            r_released <= 1'b0;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_timeout  <= 1'b0;
            r_last_ab  <= '0;
            r_hold_cnt <= '0;
            r_mask     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr      <= IW'(NUM_MASTERS - 1);
`endif
        end else begin
            r_timeout <= 1'b0;
            r_last_ab <= ab;
            r_mask    <= r_mask & req;
            case (r_state)
                ST_CPU_OWN: begin
                    if (halt_en && w_any) begin
                        r_state  <= ST_HALT_WAIT;
                        r_halt_n <= 1'b0;
                    end
                end
                ST_HALT_WAIT: begin
                    if (!w_any) begin
                        r_state    <= ST_CPU_OWN;
                        r_halt_n   <= 1'b1;
                        r_released <= 1'b0;
                    end else if (pclk1) begin
                        r_state    <= ST_DMA_OWN;
                        r_released <= 1'b1;
                        r_grant    <= w_win_oh;
                        r_gidx     <= w_win;
                        r_hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        r_ptr      <= w_win;
`endif
                    end
                end
                ST_DMA_OWN: begin
                    if (|r_grant) begin
                        if (!w_grantee_req || w_hold_hit) begin
                            r_grant <= '0;
                            if (w_grantee_req) begin
                                r_timeout <= 1'b1;
                                r_mask    <= (r_mask & req) | r_grant;
                            end
                            if (!(|w_others)) begin
                                r_state  <= ST_RETURN;
                                r_halt_n <= 1'b1;
                            end
                        end else if (pclk1) begin
                            r_hold_cnt <= r_hold_cnt + HW'(1);
                        end
                    end else if (!w_any) begin
                        r_state  <= ST_RETURN;
                        r_halt_n <= 1'b1;
                    end else if (pclk1) begin
                        r_grant    <= w_win_oh;
                        r_gidx     <= w_win;
                        r_hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        r_ptr      <= w_win;
`endif
                    end
                end
                ST_RETURN: begin
                    if (pclk1) begin
                        if (halt_en && w_any) begin
                            r_state  <= ST_HALT_WAIT;
                            r_halt_n <= 1'b0;
                        end else begin
                            r_state    <= ST_CPU_OWN;
                            r_released <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_CPU_OWN;
            endcase
        end
    end

    assign cpu_halt_n   = r_halt_n;
    assign cpu_released = r_released;
    assign grant        = r_grant;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter (fixed-priority build, NUM_MASTERS=2, MAX_HOLD=4):
// vector table, directed multi-cycle sequences, then random traffic against a reference model.
module tb_dma_bus_arbiter;
    localparam int N  = 2;
    localparam int AW = 16;
    localparam int MH = 4;

    logic          clk_sys = 1'b0;
    logic          rst, pclk1, halt_en, cpu_rw_n;
    logic [AW-1:0] cpu_ab;
    logic [N-1:0]  req;
    logic [N*AW-1:0] m_ab;
    logic          cpu_halt_n, cpu_released, rw_n, timeout;
    logic [N-1:0]  grant;
    logic [AW-1:0] ab;

    always #5 clk_sys = ~clk_sys;

    dma_bus_arbiter #(.NUM_MASTERS(N), .AW(AW), .MAX_HOLD(MH)) dut (
        .clk_sys(clk_sys), .rst(rst), .pclk1(pclk1), .halt_en(halt_en),
        .cpu_ab(cpu_ab), .cpu_rw_n(cpu_rw_n), .req(req), .m_ab(m_ab),
        .cpu_halt_n(cpu_halt_n), .cpu_released(cpu_released), .grant(grant),
        .ab(ab), .rw_n(rw_n), .timeout(timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs just after an edge, then let one edge pass and settle.
    task automatic step(input bit r, input bit he, input bit p, input bit [1:0] rq);
        rst = r; halt_en = he; pclk1 = p; req = rq;
        @(posedge clk_sys);
        #1;
    endtask

    typedef struct {
        bit        r;
        bit        he;
        bit        p;
        bit [1:0]  rq;
        bit        hn;
        bit        rel;
        bit [1:0]  g;
        bit        to;
        logic [15:0] eab;
        bit        erw;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(bit r, bit he, bit p, bit [1:0] rq, bit hn, bit rel,
                                bit [1:0] g, bit to, logic [15:0] eab, bit erw);
        vec_t v;
        v.r = r; v.he = he; v.p = p; v.rq = rq; v.hn = hn; v.rel = rel;
        v.g = g; v.to = to; v.eab = eab; v.erw = erw;
        return v;
    endfunction

    // Reference model: ownership described by halted/released/waiting flags and an owner index.
    bit          mh, mrel, mwait, mto;
    int          mown, mheld;
    bit [1:0]    mmask;
    logic [15:0] mlast;

    task automatic model_reset();
        mh = 0; mrel = 0; mwait = 0; mto = 0; mown = -1; mheld = 0; mmask = '0; mlast = '0;
    endtask

    function automatic int lowest(bit [1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_bus(output logic [15:0] eab, output logic erw);
        if (mwait || (!mh && !mrel)) begin
            eab = cpu_ab; erw = cpu_rw_n;
        end else if (mh && mown >= 0) begin
            eab = m_ab[mown*AW +: AW]; erw = 1'b1;
        end else begin
            eab = mlast; erw = 1'b1;
        end
    endtask

    task automatic model_step(input bit r, input bit he, input bit p, input bit [1:0] rq);
        logic [15:0] eab;
        logic        erw;
        bit [1:0]    eff, others, newmask;
        bit          still, expire;
        model_bus(eab, erw);
        if (r) begin
            model_reset();
            return;
        end
        mlast   = eab;
        mto     = 0;
        eff     = rq & ~mmask;
        newmask = mmask & rq;
        if (mwait) begin
            if (eff == 0) begin mwait = 0; mh = 0; mrel = 0; end
            else if (p) begin mwait = 0; mrel = 1; mown = lowest(eff); mheld = 0; end
        end else if (!mh && !mrel) begin
            if (he && eff != 0) begin mwait = 1; mh = 1; end
        end else if (!mh && mrel) begin
            if (p) begin
                if (he && eff != 0) begin mwait = 1; mh = 1; end
                else mrel = 0;
            end
        end else if (mown >= 0) begin
            still = rq[mown];
            if (p) mheld++;
            expire = p && (mheld == MH);
            if (!still || expire) begin
                if (still) begin mto = 1; newmask[mown] = 1'b1; end
                others = eff;
                others[mown] = 1'b0;
                mown = -1;
                if (others == 0) mh = 0;
            end
        end else begin
            if (eff == 0) mh = 0;
            else if (p) begin mown = lowest(eff); mheld = 0; end
        end
        mmask = newmask;
    endtask

    initial begin
        int rises, strobes, to_cycles, to_bad;
        bit seen;
        bit [1:0] prev_g, rq;
        logic [15:0] eab;
        logic erw;
        bit he, r;

        rst = 1; halt_en = 1; pclk1 = 0; req = '0;
        cpu_ab = 16'h1234; cpu_rw_n = 1'b0; m_ab = {16'hB111, 16'hA000};

        vt[0]  = mk(1, 1, 0, 2'b00, 1, 0, 2'b00, 0, 16'h1234, 0);
        vt[1]  = mk(0, 1, 0, 2'b00, 1, 0, 2'b00, 0, 16'h1234, 0);
        vt[2]  = mk(0, 1, 1, 2'b00, 1, 0, 2'b00, 0, 16'h1234, 0);
        vt[3]  = mk(0, 1, 0, 2'b01, 0, 0, 2'b00, 0, 16'h1234, 0);
        vt[4]  = mk(0, 1, 0, 2'b01, 0, 0, 2'b00, 0, 16'h1234, 0);
        vt[5]  = mk(0, 1, 1, 2'b01, 0, 1, 2'b01, 0, 16'hA000, 1);
        vt[6]  = mk(0, 1, 0, 2'b01, 0, 1, 2'b01, 0, 16'hA000, 1);
        vt[7]  = mk(0, 1, 0, 2'b00, 1, 1, 2'b00, 0, 16'hA000, 1);
        vt[8]  = mk(0, 1, 0, 2'b00, 1, 1, 2'b00, 0, 16'hA000, 1);
        vt[9]  = mk(0, 1, 1, 2'b00, 1, 0, 2'b00, 0, 16'h1234, 0);
        vt[10] = mk(0, 1, 0, 2'b11, 0, 0, 2'b00, 0, 16'h1234, 0);
        vt[11] = mk(0, 1, 1, 2'b11, 0, 1, 2'b01, 0, 16'hA000, 1);
        vt[12] = mk(0, 1, 0, 2'b10, 0, 1, 2'b00, 0, 16'hA000, 1);
        vt[13] = mk(0, 1, 0, 2'b10, 0, 1, 2'b00, 0, 16'hA000, 1);
        vt[14] = mk(0, 1, 1, 2'b10, 0, 1, 2'b10, 0, 16'hB111, 1);
        vt[15] = mk(0, 1, 1, 2'b11, 0, 1, 2'b10, 0, 16'hB111, 1);
        vt[16] = mk(0, 1, 0, 2'b00, 1, 1, 2'b00, 0, 16'hB111, 1);
        vt[17] = mk(0, 1, 1, 2'b01, 0, 1, 2'b00, 0, 16'h1234, 0);
        vt[18] = mk(0, 1, 1, 2'b01, 0, 1, 2'b01, 0, 16'hA000, 1);
        vt[19] = mk(0, 1, 0, 2'b00, 1, 1, 2'b00, 0, 16'hA000, 1);
        vt[20] = mk(0, 1, 1, 2'b00, 1, 0, 2'b00, 0, 16'h1234, 0);

        @(posedge clk_sys);
        #1;
        for (int i = 0; i < 21; i++) begin
            step(vt[i].r, vt[i].he, vt[i].p, vt[i].rq);
            chk($sformatf("vec%0d.halt_n", i),   cpu_halt_n,   vt[i].hn);
            chk($sformatf("vec%0d.released", i), cpu_released, vt[i].rel);
            chk($sformatf("vec%0d.grant", i),    grant,        vt[i].g);
            chk($sformatf("vec%0d.timeout", i),  timeout,      vt[i].to);
            chk($sformatf("vec%0d.ab", i),       ab,           vt[i].eab);
            chk($sformatf("vec%0d.rw_n", i),     rw_n,         vt[i].erw);
        end

        // halt_en low: requests ignored
        for (int i = 0; i < 100; i++) begin
            step(0, 0, (i % 4) == 3, 2'b11);
            chk("gate.halt_n", cpu_halt_n, 1'b1);
            chk("gate.grant", grant, 2'b00);
        end

        // request withdrawn before pclk1
        step(0, 1, 0, 2'b00);
        step(0, 1, 0, 2'b01);
        chk("cancel.halt_n_low", cpu_halt_n, 1'b0);
        step(0, 1, 0, 2'b01);
        chk("cancel.grant_wait", grant, 2'b00);
        step(0, 1, 0, 2'b00);
        chk("cancel.halt_n_back", cpu_halt_n, 1'b1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, i[0], 2'b00);
            if (grant != 0) seen = 1;
        end
        chk("cancel.no_grant", seen, 1'b0);
        chk("cancel.released", cpu_released, 1'b0);

        // MAX_HOLD expiry with request held
        rises = 0; strobes = 0; to_cycles = 0; to_bad = 0;
        for (int i = 0; i < 60; i++) begin
            prev_g = grant;
            step(0, 1, (i % 3) == 2, 2'b01);
            if (pclk1 && prev_g == 2'b01) strobes++;
            if (prev_g == 0 && grant != 0) rises++;
            if (timeout) begin
                to_cycles++;
                if (grant != 0) to_bad++;
            end
        end
        chk("hold.strobes", strobes, MH);
        chk("hold.grant_rises", rises, 1);
        chk("hold.timeout_cycles", to_cycles, 1);
        chk("hold.grant_at_timeout", to_bad, 0);
        chk("hold.halt_n_after", cpu_halt_n, 1'b1);
        step(0, 1, 0, 2'b00);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(0, 1, (i % 3) == 2, 2'b01);
            if (grant == 2'b01) seen = 1;
        end
        chk("hold.regrant_after_release", seen, 1'b1);

        // reset while a master owns the bus
        step(1, 1, 0, 2'b01);
        chk("rst.grant", grant, 2'b00);
        chk("rst.halt_n", cpu_halt_n, 1'b1);
        chk("rst.released", cpu_released, 1'b0);
        chk("rst.ab", ab, 16'h1234);
        chk("rst.timeout", timeout, 1'b0);

        // random traffic against the model
        step(1, 1, 0, 2'b00);
        model_reset();
        rq = '0; he = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
            if ($urandom_range(0, 49) == 0) he = ~he;
            r = ($urandom_range(0, 399) == 0);
            rst = r; halt_en = he; req = rq;
            pclk1 = ((c % 3) == 0);
            cpu_ab = 16'($urandom); cpu_rw_n = 1'($urandom); m_ab = 32'($urandom);
            #1;
            model_bus(eab, erw);
            chk("rnd.halt_n", cpu_halt_n, !mh);
            chk("rnd.released", cpu_released, mrel);
            chk("rnd.grant", grant, (mown >= 0) ? (32'd1 << mown) : 32'd0);
            chk("rnd.timeout", timeout, mto);
            chk("rnd.ab", ab, eab);
            chk("rnd.rw_n", rw_n, erw);
            model_step(r, he, pclk1, rq);
            @(posedge clk_sys);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
